// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master single-port memory arbiter.
package mem_arbiter_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = 4;
   localparam int unsigned CNT_W  = 4;

   // Read-owner / winner encoding
   typedef enum logic {
      ARB_M0 = 1'b0,
      ARB_M1 = 1'b1
   } arb_owner_e;

   // Command presented to the RAM port
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [BE_W-1:0]   we;
      logic [DATA_W-1:0] d;
   } mem_cmd_t;

   // Byte address to word-aligned address
   function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a);
      return a & ~ADDR_W'(3);
   endfunction

endpackage

// File: rtl/mem_arb_sel.sv
// Combinational grant selection between fetch (m0) and data (m1) requesters.
module mem_arb_sel
   import mem_arbiter_pkg::*;
(
   input  logic       [1:0] reqs,
   input  logic             starve,
   input  arb_owner_e       last_winner,
   output logic       [1:0] gnt
);

   // Lone requester wins; on conflict m0 wins if starving or if m1 won last
   always_comb begin
      gnt = reqs;
      if (reqs == 2'b11) begin
         gnt = (starve || (last_winner == ARB_M1)) ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single-port RAM with 1-cycle read latency.
// Optional MEM_ARB_RR_EN: round-robin conflict resolution instead of
// fixed m1 priority with m0 anti-starvation.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m0_req,
   input  logic [ADDR_W-1:0] m0_addr,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [BE_W-1:0]   m1_we,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_d,
   output logic [BE_W-1:0]   mem_we,
   input  logic [DATA_W-1:0] mem_q
);

   logic              ready_q;
   logic              rd_pend_q;
   arb_owner_e        owner_q;
   logic [DATA_W-1:0] m0_rdata_q;
   logic [DATA_W-1:0] m1_rdata_q;
   logic [1:0]        gnt;
   logic              starve;
   arb_owner_e        last_winner;
   mem_cmd_t          cmd;
   logic              m1_rd;

`ifdef MEM_ARB_RR_EN
   arb_owner_e last_winner_q;

   assign starve      = 1'b0;
   assign last_winner = last_winner_q;

   // Remember who won the most recent grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_winner_q <= ARB_M0;
      end else if (gnt[0]) begin
         last_winner_q <= ARB_M0;
      end else if (gnt[1]) begin
         last_winner_q <= ARB_M1;
      end
   end
`else
   logic [CNT_W-1:0] starve_cnt_q;

   assign starve      = (starve_cnt_q == CNT_W'(STARVE_LIMIT));
   assign last_winner = ARB_M0;

   // Count m1 grants taken while m0 waits; saturates at the limit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt_q <= '0;
      end else if (!m0_req || gnt[0]) begin
         starve_cnt_q <= '0;
      end else if (gnt[1] && !starve) begin
         starve_cnt_q <= starve_cnt_q + CNT_W'(1);
      end
   end
`endif

   mem_arb_sel u_sel (
      .reqs        ({m1_req, m0_req} & {2{ready_q}}),
      .starve      (starve),
      .last_winner (last_winner),
      .gnt         (gnt)
   );

   assign m0_gnt = gnt[0];
   assign m1_gnt = gnt[1];
   assign mem_en = |gnt;
   assign m1_rd  = gnt[1] && (m1_we == '0);

   // Route the granted requester onto the RAM port; fetches never write
   always_comb begin
      cmd = '0;
      if (gnt[1]) begin
         cmd.addr = word_addr(m1_addr);
         cmd.we   = m1_we;
         cmd.d    = m1_wdata;
      end else if (gnt[0]) begin
         cmd.addr = word_addr(m0_addr);
      end
   end

   assign mem_addr = cmd.addr;
   assign mem_we   = cmd.we;
   assign mem_d    = cmd.d;

   // Ready flag plus read-pending / owner tag steering next-cycle mem_q
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q   <= 1'b0;
         rd_pend_q <= 1'b0;
         owner_q   <= ARB_M0;
      end else begin
         ready_q   <= 1'b1;
         rd_pend_q <= gnt[0] || m1_rd;
         if (gnt[1]) begin
            owner_q <= ARB_M1;
         end else if (gnt[0]) begin
            owner_q <= ARB_M0;
         end
      end
   end

   assign m0_rvalid = rd_pend_q && (owner_q == ARB_M0);
   assign m1_rvalid = rd_pend_q && (owner_q == ARB_M1);

   // Hold the last returned word for each requester
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m0_rdata_q <= '0;
         m1_rdata_q <= '0;
      end else begin
         if (m0_rvalid) m0_rdata_q <= mem_q;
         if (m1_rvalid) m1_rdata_q <= mem_q;
      end
   end

   assign m0_rdata = m0_rvalid ? mem_q : m0_rdata_q;
   assign m1_rdata = m1_rvalid ? mem_q : m1_rdata_q;

endmodule
